// File: rtl/apb_arb_pkg.sv
// Shared types for the APB request arbiter: FSM state encoding and
// transfer direction constants.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Round-robin winner selection: a double-width priority encoder whose lower
// copy is masked below the pointer, so the search wraps past the top requester.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               found
);

  logic [NUM_REQ-1:0]   hi_s;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic                 hit_s;

  // lowest set bit of {req, req & (bits >= ptr)} is the next owner
  always_comb begin
    hi_s  = '0;
    win   = '0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      hi_s[k] = (32'(k) >= 32'(ptr));
    end
    dbl_s = {req, req & hi_s};
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (dbl_s[i] && !hit_s) begin
        win[i % NUM_REQ] = 1'b1;
        hit_s            = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
    found = hit_s;
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NUM_REQ requesters: round-robin capture,
// valid/ready issue, response routing back to the owner, and a sleep handshake.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           i_clk_apb,
  input  logic                           i_rstn_apb,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_wr_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  output logic                           o_valid,
  output logic                           o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]          o_addr,
  output logic [DATA_WIDTH-1:0]          o_wr_data,
  input  logic                           i_ready,
  input  logic                           i_rd_valid,
  input  logic [DATA_WIDTH-1:0]          i_rd_data,
  input  logic                           i_sleep_req,
  output logic                           o_sleep_ack,
  output logic [NUM_REQ-1:0]             o_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e              state_r;
  logic [PTR_W-1:0]        rr_ptr_r;
  logic [NUM_REQ-1:0]      win_s;
  logic                    found_s;
  logic                    sel_dir_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;

  // Pointer lands just past the requester that was served last.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_REQ-1:0] gnt);
    logic [PTR_W-1:0] nxt;
    nxt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        nxt = (k == NUM_REQ-1) ? '0 : PTR_W'(k + 1);
      end else begin
        nxt = nxt;
      end
    end
    return nxt;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (i_req_valid),
    .ptr   (rr_ptr_r),
    .win   (win_s),
    .found (found_s)
  );

  // AND-OR mux of the winning requester's fields
  always_comb begin
    sel_dir_s  = 1'b0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_dir_s  = sel_dir_s | (i_req_rd0_wr1[k] & win_s[k]);
      sel_addr_s = sel_addr_s | (i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{win_s[k]}});
      sel_data_s = sel_data_s | (i_req_wr_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{win_s[k]}});
    end
  end

  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_valid     <= 1'b0;
      o_rd0_wr1   <= RD;
      o_addr      <= '0;
      o_wr_data   <= '0;
      o_sleep_ack <= 1'b0;
      o_grant     <= '0;
    end else begin
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_sleep_ack <= (state_r == IDLE) && i_sleep_req;
      case (state_r)
        IDLE: begin
          if (!i_sleep_req && found_s) begin
            o_rd0_wr1   <= sel_dir_s;
            o_addr      <= sel_addr_s;
            o_wr_data   <= sel_data_s;
            o_grant     <= win_s;
            o_req_ready <= win_s;
            o_valid     <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            state_r <= WAIT_RSP;
          end else begin
            state_r <= ISSUE;
          end
        end
        WAIT_RSP: begin
          // reads finish on the data pulse, writes when the master is idle again
          if (o_rd0_wr1 == RD) begin
            if (i_rd_valid) begin
              o_rsp_data  <= i_rd_data;
              o_rsp_valid <= o_grant;
              state_r     <= RESP;
            end else begin
              state_r <= WAIT_RSP;
            end
          end else if (i_ready) begin
            o_rsp_data  <= '0;
            o_rsp_valid <= o_grant;
            state_r     <= RESP;
          end else begin
            state_r <= WAIT_RSP;
          end
        end
        RESP: begin
          rr_ptr_r   <= next_ptr(o_grant);
          o_grant    <= '0;
          o_rsp_data <= '0;
          state_r    <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_grant <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a transaction-level reference model
// compared against the DUT on every falling clock edge.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_dir = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic            ready = 1'b1;
  logic            rd_valid = 1'b0;
  logic [DW-1:0]   rd_data = '0;
  logic            sleep_req = 1'b0;

  logic [N-1:0]    o_req_ready, o_rsp_valid, o_grant;
  logic [DW-1:0]   o_rsp_data, o_wr_data;
  logic [AW-1:0]   o_addr;
  logic            o_valid, o_rd0_wr1, o_sleep_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk_apb     (clk),
    .i_rstn_apb    (rst_n),
    .i_req_valid   (req_valid),
    .i_req_rd0_wr1 (req_dir),
    .i_req_addr    (req_addr),
    .i_req_wr_data (req_wdata),
    .o_req_ready   (o_req_ready),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_data    (o_rsp_data),
    .o_valid       (o_valid),
    .o_rd0_wr1     (o_rd0_wr1),
    .o_addr        (o_addr),
    .o_wr_data     (o_wr_data),
    .i_ready       (ready),
    .i_rd_valid    (rd_valid),
    .i_rd_data     (rd_data),
    .i_sleep_req   (sleep_req),
    .o_sleep_ack   (o_sleep_ack),
    .o_grant       (o_grant)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one transfer at a time ----------------
  int           m_owner = -1;
  int           m_ptr = 0;
  bit           m_acc = 1'b0;
  bit           m_done = 1'b0;
  int           m_order[$];
  logic [N-1:0] e_req_ready = '0, e_rsp_valid = '0, e_grant = '0;
  logic [DW-1:0] e_rsp_data = '0, e_wdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic          e_valid = 1'b0, e_dir = 1'b0, e_ack = 1'b0;

  task automatic model_step();
    int w;
    w = -1;
    e_ack       = (m_owner < 0) && sleep_req;
    e_req_ready = '0;
    e_rsp_valid = '0;
    if (m_owner < 0) begin
      if (!sleep_req) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (w < 0 && req_valid[c]) w = c;
        end
      end
      if (w >= 0) begin
        m_owner     = w;
        e_grant     = '0;
        e_grant[w]  = 1'b1;
        e_req_ready = e_grant;
        e_valid     = 1'b1;
        e_dir       = req_dir[w];
        e_addr      = req_addr[w*AW +: AW];
        e_wdata     = req_wdata[w*DW +: DW];
        m_order.push_back(w);
      end
    end else if (!m_acc) begin
      if (ready) begin
        m_acc   = 1'b1;
        e_valid = 1'b0;
      end
    end else if (!m_done) begin
      if (e_dir ? ready : rd_valid) begin
        m_done      = 1'b1;
        e_rsp_valid = e_grant;
        e_rsp_data  = e_dir ? '0 : rd_data;
      end
    end else begin
      m_ptr      = (m_owner + 1) % N;
      m_owner    = -1;
      m_acc      = 1'b0;
      m_done     = 1'b0;
      e_grant    = '0;
      e_rsp_data = '0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_acc = 1'b0; m_done = 1'b0;
      e_req_ready = '0; e_rsp_valid = '0; e_grant = '0; e_rsp_data = '0;
      e_wdata = '0; e_addr = '0; e_valid = 1'b0; e_dir = 1'b0; e_ack = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("cmp_req_ready", 64'(o_req_ready), 64'(e_req_ready));
    chk("cmp_rsp_valid", 64'(o_rsp_valid), 64'(e_rsp_valid));
    chk("cmp_rsp_data",  64'(o_rsp_data),  64'(e_rsp_data));
    chk("cmp_valid",     64'(o_valid),     64'(e_valid));
    chk("cmp_dir",       64'(o_rd0_wr1),   64'(e_dir));
    chk("cmp_addr",      64'(o_addr),      64'(e_addr));
    chk("cmp_wdata",     64'(o_wr_data),   64'(e_wdata));
    chk("cmp_grant",     64'(o_grant),     64'(e_grant));
    chk("cmp_sleep_ack", 64'(o_sleep_ack), 64'(e_ack));
  end

  // ---------------- auto master: accept, busy 3 cycles, complete ----------------
  bit auto_m = 1'b0;
  int mst_cnt = 0;
  always @(negedge clk) begin
    if (auto_m) begin
      if (mst_cnt == 0) begin
        if (o_valid && ready) mst_cnt = 1;
      end else if (mst_cnt == 1) begin
        ready = 1'b0; mst_cnt = 2;
      end else if (mst_cnt < 4) begin
        mst_cnt++;
      end else begin
        ready = 1'b1; mst_cnt = 0;
      end
    end
  end

  task automatic wait_rsp(input string name, input logic [N-1:0] vec, input logic [DW-1:0] data);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_rsp_valid != '0) begin
        seen = 1'b1;
        chk({name, "_vec"}, 64'(o_rsp_valid), 64'(vec));
        chk({name, "_data"}, 64'(o_rsp_data), 64'(data));
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    int dut_order[$];
    int exp_order[5];
    bit idle;
    exp_order = '{0, 1, 2, 3, 0};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(o_grant), 64'h0);
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_ack",   64'(o_sleep_ack), 64'h0);
    chk("rst_addr",  64'(o_addr), 64'h0);
    #2 rst_n = 1'b1;

    // single read from requester 2
    @(negedge clk);
    req_addr[2*AW +: AW] = 32'h0000_0040; req_dir[2] = 1'b0; req_valid[2] = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", 64'(o_req_ready), 64'h4);
    chk("t1_valid",     64'(o_valid), 64'h1);
    chk("t1_addr",      64'(o_addr), 64'h40);
    req_valid[2] = 1'b0;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    @(negedge clk); rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF; ready = 1'b1;
    @(negedge clk); rd_valid = 1'b0;
    chk("t1_rsp_valid", 64'(o_rsp_valid), 64'h4);
    chk("t1_rsp_data",  64'(o_rsp_data), 64'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_rsp_pulse", 64'(o_rsp_valid), 64'h0);
    chk("t1_grant_off", 64'(o_grant), 64'h0);

    // all four writing continuously from a fresh pointer
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    m_order.delete();
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = 32'h100 * k;
      req_wdata[k*DW +: DW] = 32'hA000 + k;
    end
    req_dir = '1; req_valid = '1; ready = 1'b1; auto_m = 1'b1;
    for (int i = 0; i < 200 && dut_order.size() < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (o_req_ready[k]) dut_order.push_back(k);
      if (o_rsp_valid != '0) chk("t2_wr_rsp_zero", 64'(o_rsp_data), 64'h0);
    end
    req_valid = '0;
    chk("t2_grant_count", 64'(dut_order.size()), 64'd5);
    for (int i = 0; i < 5 && i < dut_order.size(); i++) begin
      chk("t2_order", 64'(dut_order[i]), 64'(exp_order[i]));
      chk("t2_model_order", 64'(m_order[i]), 64'(exp_order[i]));
    end
    idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk);
      if (o_grant == '0 && mst_cnt == 0) idle = 1'b1;
    end
    chk("t2_drain", 64'(idle), 64'h1);
    auto_m = 1'b0; ready = 1'b1;

    // back-pressure: requester 3 write held off for 5 cycles
    @(negedge clk);
    req_addr[3*AW +: AW] = 32'h0000_300C; req_wdata[3*DW +: DW] = 32'h5555_AAAA;
    req_dir[3] = 1'b1; req_valid[3] = 1'b1; ready = 1'b0;
    @(negedge clk);
    chk("t3_req_ready", 64'(o_req_ready), 64'h8);
    req_valid[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("t3_no_second_ready", 64'(o_req_ready), 64'h0);
      end
      chk("t3_valid_hold", 64'(o_valid), 64'h1);
      chk("t3_addr_hold",  64'(o_addr), 64'h300C);
      chk("t3_data_hold",  64'(o_wr_data), 64'h5555_AAAA);
    end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    @(negedge clk); ready = 1'b1;
    wait_rsp("t3_rsp", 4'b1000, 32'h0);

    // sleep raised while a read waits for data
    @(negedge clk);
    req_addr[0] = 1'b0; req_addr[0*AW +: AW] = 32'h10; req_dir[0] = 1'b0; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t4_grant0", 64'(o_grant), 64'h1);
    req_valid[0] = 1'b0;
    req_addr[1*AW +: AW] = 32'h14; req_dir[1] = 1'b0; req_valid[1] = 1'b1;
    @(negedge clk); ready = 1'b0; sleep_req = 1'b1;
    @(negedge clk);
    @(negedge clk); rd_valid = 1'b1; rd_data = 32'h1234_5678; ready = 1'b1;
    @(negedge clk); rd_valid = 1'b0;
    chk("t4_rsp_valid", 64'(o_rsp_valid), 64'h1);
    chk("t4_rsp_data",  64'(o_rsp_data), 64'h1234_5678);
    chk("t4_ack_resp",  64'(o_sleep_ack), 64'h0);
    @(negedge clk);
    chk("t4_ack_idle1", 64'(o_sleep_ack), 64'h0);
    @(negedge clk);
    chk("t4_ack_set", 64'(o_sleep_ack), 64'h1);
    repeat (4) begin
      @(negedge clk);
      chk("t4_no_grant", 64'(o_grant), 64'h0);
    end
    sleep_req = 1'b0;
    @(negedge clk);
    chk("t4_grant1", 64'(o_grant), 64'h2);
    chk("t4_ack_drop", 64'(o_sleep_ack), 64'h0);
    req_valid[1] = 1'b0;
    @(negedge clk); ready = 1'b0;
    @(negedge clk); rd_valid = 1'b1; rd_data = 32'hCAFE_0001; ready = 1'b1;
    @(negedge clk); rd_valid = 1'b0;
    chk("t4b_rsp_valid", 64'(o_rsp_valid), 64'h2);
    chk("t4b_rsp_data",  64'(o_rsp_data), 64'hCAFE_0001);

    // reset in WAIT_RSP, then a fresh grant from requester 0
    @(negedge clk);
    req_addr[2*AW +: AW] = 32'h88; req_dir[2] = 1'b0; req_valid[2] = 1'b1;
    @(negedge clk);
    chk("t5_grant2", 64'(o_grant), 64'h4);
    req_valid[2] = 1'b0;
    req_addr[0*AW +: AW] = 32'h0000_0A00; req_wdata[0*DW +: DW] = 32'h0BAD_F00D; req_dir[0] = 1'b1;
    req_addr[3*AW +: AW] = 32'h0000_0A03; req_dir[3] = 1'b1;
    req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    chk("t5_in_wait", 64'(o_grant), 64'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 64'(o_grant), 64'h0);
    chk("t5_rst_addr",  64'(o_addr), 64'h0);
    chk("t5_rst_valid", 64'(o_valid), 64'h0);
    chk("t5_rst_ready", 64'(o_req_ready), 64'h0);
    @(negedge clk); #2 rst_n = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("t5_fresh_grant", 64'(o_grant), 64'h1);
    chk("t5_fresh_addr",  64'(o_addr), 64'hA00);
    req_valid = '0;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    @(negedge clk); ready = 1'b1;
    wait_rsp("t5_rsp", 4'b0001, 32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
